npc_sequencer: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives instruction memory through a req/ack handshake. It replaces free-running PC stepping with a state machine that arbitrates between sequential fetch, control-flow redirects from execute, and exceptions. It sits between instruction memory and decode, handing one instruction at a time to decode under a valid/ready handshake.

---
 rtl/npc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_npc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_sequencer.sv
// npc_sequencer
// Instruction-fetch sequencer. Owns the program counter, drives instruction
// memory through a req/ack handshake, and hands one instruction at a time to
// decode through a valid/ready handshake. Arbitrates between sequential fetch,
// control-flow redirects from execute and exceptions (exception wins).
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   PcReSet      synchronous active-high reset
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address (the current pc)
//   imem_ack     memory accepted the request, imem_rdata valid this cycle
//   imem_rdata   fetched word
//   inst_valid   inst/inst_pc valid for decode
//   inst         fetched instruction
//   inst_pc      address of inst
//   inst_ready   decode consumes inst this cycle
//   redir_valid  control-flow redirect from execute
//   NPCOp        redirect kind: 00 refetch, 01 jr, 10 j, 11 branch
//   Adress       jr target / j index [25:0] / branch offset [15:0]
//   redir_pc     PC of the redirecting instruction
//   exc_valid    exception, overrides a redirect on the same edge
//   pc           current fetch PC

module npc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        PcReSet,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] Adress,
    input  logic [31:0] redir_pc,
    input  logic        exc_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        VALID = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t      state;
    logic [31:0] pending;
    logic        pending_exc;

    logic [31:0] link_pc;
    logic [31:0] branch_off;
    logic [31:0] redir_target;
    logic [31:0] target;
    logic        take;
    logic        drain_update;
    logic [31:0] pending_next;
    logic        pending_exc_next;

    // The address presented to memory is always the fetch pc. While a
    // request is waiting for its ack the pc only moves when the ack arrives,
    // which keeps the address stable across wait states.
    assign imem_addr = pc;

    // Target selection for redirects and exceptions. An exception overrides
    // any redirect on the same edge. Inside DRAIN a newer redirect replaces
    // the pending target, except that a plain redirect may never displace a
    // pending exception target. The merged value is also what gets loaded
    // if the outstanding ack lands on the same edge as a new redirect.
    always_comb begin
        link_pc    = redir_pc + 32'd4;
        branch_off = {{14{Adress[15]}}, Adress[15:0], 2'b00};
        case (NPCOp)
            2'b00:   redir_target = link_pc;
            2'b01:   redir_target = Adress;
            2'b10:   redir_target = {link_pc[31:28], Adress[25:0], 2'b00};
            default: redir_target = link_pc + branch_off;
        endcase
        target           = exc_valid ? EXC_VECTOR : redir_target;
        take             = exc_valid | redir_valid;
        drain_update     = exc_valid | (redir_valid & ~pending_exc);
        pending_next     = drain_update ? target : pending;
        pending_exc_next = pending_exc | exc_valid;
    end

    // Fetch state machine. All outputs are registers updated alongside the
    // state so that imem_req and inst_valid never depend on inputs
    // combinationally. Reset wins over everything and simply abandons any
    // outstanding memory request.
    always_ff @(posedge clk) begin
        if (PcReSet) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= 32'd0;
            inst_pc     <= RESET_PC;
            pending     <= 32'd0;
            pending_exc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        pc <= target;
                    end
                    imem_req <= 1'b1;
                    state    <= REQ;
                end

                REQ: begin
                    if (imem_ack) begin
                        if (take) begin
                            pc <= target;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            imem_req   <= 1'b0;
                            inst_valid <= 1'b1;
                            state      <= VALID;
                        end
                    end else if (take) begin
                        pending     <= target;
                        pending_exc <= exc_valid;
                        state       <= DRAIN;
                    end
                end

                DRAIN: begin
                    pending <= pending_next;
                    if (imem_ack) begin
                        pc          <= pending_next;
                        pending_exc <= 1'b0;
                        state       <= REQ;
                    end else begin
                        pending_exc <= pending_exc_next;
                    end
                end

                VALID: begin
                    if (take) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        pc         <= pc + 32'd4;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_sequencer.sv
// tb_npc_sequencer
// Self-checking bench for npc_sequencer: a table of directed vectors for the
// documented scenarios, a hand-written wait-state latency sequence, and a
// randomized run compared against a transaction-level reference model.

module tb_npc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        PcReSet;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [1:0]  NPCOp;
    logic [31:0] Adress;
    logic [31:0] redir_pc;
    logic        exc_valid;
    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    npc_sequencer dut (
        .clk        (clk),
        .PcReSet    (PcReSet),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redir_valid(redir_valid),
        .NPCOp      (NPCOp),
        .Adress     (Adress),
        .redir_pc   (redir_pc),
        .exc_valid  (exc_valid),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [1:0]  op;
        logic [31:0] adr;
        logic [31:0] rpc;
        logic        exc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: what the fetch unit should be presenting.
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_pend;
    logic        m_pend_exc;
    logic        m_drain;

    function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic redir, input logic [1:0] op,
                                input logic [31:0] adr, input logic [31:0] rpc, input logic exc,
                                input logic ereq, input logic [31:0] eaddr, input logic evalid,
                                input logic [31:0] einst, input logic [31:0] eipc);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir;
        v.op = op; v.adr = adr; v.rpc = rpc; v.exc = exc;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_inst = einst; v.exp_ipc = eipc;
        return v;
    endfunction

    // Target address straight from the arithmetic rules.
    function automatic logic [31:0] refTarget(input logic [1:0] op, input logic [31:0] adr,
                                              input logic [31:0] rpc, input logic exc);
        logic [31:0] nxt;
        logic signed [15:0] off16;
        int off;
        nxt   = rpc + 32'd4;
        off16 = adr[15:0];
        off   = int'(off16);
        if (exc) return EXC_PC;
        case (op)
            2'd0:    return nxt;
            2'd1:    return adr;
            2'd2:    return (nxt & 32'hF000_0000) | ((adr & 32'h03FF_FFFF) * 32'd4);
            default: return nxt + 32'(off * 4);
        endcase
    endfunction

    task automatic modelStep();
        logic [31:0] tgt;
        logic take;
        if (PcReSet) begin
            m_pc = RST_PC; m_req = 1'b0; m_valid = 1'b0; m_inst = 32'd0;
            m_ipc = RST_PC; m_pend = 32'd0; m_pend_exc = 1'b0; m_drain = 1'b0;
            return;
        end
        take = exc_valid || redir_valid;
        tgt  = refTarget(NPCOp, Adress, redir_pc, exc_valid);
        if (m_valid) begin
            if (take) begin
                m_pc = tgt; m_valid = 1'b0; m_req = 1'b1;
            end else if (inst_ready) begin
                m_pc = m_pc + 32'd4; m_valid = 1'b0; m_req = 1'b1;
            end
        end else if (!m_req) begin
            if (take) m_pc = tgt;
            m_req = 1'b1;
        end else if (m_drain) begin
            if (take && (exc_valid || !m_pend_exc)) begin
                m_pend = tgt;
                m_pend_exc = m_pend_exc || exc_valid;
            end
            if (imem_ack) begin
                m_pc = m_pend; m_drain = 1'b0; m_pend_exc = 1'b0;
            end
        end else begin
            if (imem_ack && !take) begin
                m_inst = imem_rdata; m_ipc = m_pc; m_valid = 1'b1; m_req = 1'b0;
            end else if (imem_ack) begin
                m_pc = tgt;
            end else if (take) begin
                m_pend = tgt; m_pend_exc = exc_valid; m_drain = 1'b1;
            end
        end
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ereq, input logic [31:0] eaddr,
                               input logic evalid, input logic [31:0] einst,
                               input logic [31:0] eipc);
        checkField({name, ".imem_req"},   {31'd0, imem_req},   {31'd0, ereq});
        checkField({name, ".imem_addr"},  imem_addr,           eaddr);
        checkField({name, ".pc"},         pc,                  eaddr);
        checkField({name, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, evalid});
        checkField({name, ".inst"},       inst,                einst);
        checkField({name, ".inst_pc"},    inst_pc,             eipc);
    endtask

    task automatic clearInputs();
        PcReSet = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        redir_valid = 1'b0; NPCOp = 2'd0; Adress = 32'd0; redir_pc = 32'd0; exc_valid = 1'b0;
    endtask

    // Drive one vector ahead of a rising edge and settle just after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        PcReSet = v.rst; imem_ack = v.ack; imem_rdata = v.rdata; inst_ready = v.ready;
        redir_valid = v.redir; NPCOp = v.op; Adress = v.adr; redir_pc = v.rpc;
        exc_valid = v.exc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // rst ack rdata ready redir op adr rpc exc | req addr valid inst inst_pc
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(0,1,32'h1111_0000,1,0,0,0,0,0, 0,RST_PC,1,32'h1111_0000,RST_PC));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 1,32'h0040_0004,0,32'h1111_0000,RST_PC));
        vecs.push_back(mk(0,1,32'h1111_0001,1,0,0,0,0,0, 0,32'h0040_0004,1,32'h1111_0001,32'h0040_0004));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 1,32'h0040_0008,0,32'h1111_0001,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,32'h0040_0008,0,32'h1111_0001,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,32'h0040_0008,0,32'h1111_0001,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,32'h0040_0008,0,32'h1111_0001,32'h0040_0004));
        vecs.push_back(mk(0,1,32'h1111_0002,0,0,0,0,0,0, 0,32'h0040_0008,1,32'h1111_0002,32'h0040_0008));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,32'h0040_0008,1,32'h1111_0002,32'h0040_0008));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,32'h0040_0008,1,32'h1111_0002,32'h0040_0008));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 1,32'h0040_000C,0,32'h1111_0002,32'h0040_0008));
        vecs.push_back(mk(0,1,32'h1111_0003,0,0,0,0,0,0, 0,32'h0040_000C,1,32'h1111_0003,32'h0040_000C));
        vecs.push_back(mk(0,0,0,0,1,3,32'hFFFF_FFFC,32'h0040_0010,0, 1,32'h0040_0004,0,32'h1111_0003,32'h0040_000C));
        vecs.push_back(mk(0,1,32'h1111_0004,0,0,0,0,0,0, 0,32'h0040_0004,1,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,1,2,32'h0000_0100,32'h0040_0020,0, 1,32'h0000_0400,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,1,32'h5555_5555,0,1,1,32'h1234_5678,0,0, 1,32'h1234_5678,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,1,32'h6666_6666,0,1,0,0,RST_PC,0, 1,32'h0040_0004,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,1,3,32'h0000_0010,32'h0040_0100,0, 1,32'h0040_0004,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,32'h0040_0004,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0,0,0,0, 1,32'h0040_0144,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,1,32'h7777_7777,0,1,3,0,0,1, 1,EXC_PC,0,32'h1111_0004,32'h0040_0004));
        vecs.push_back(mk(0,1,32'h1111_0005,0,0,0,0,0,0, 0,EXC_PC,1,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 1,32'h8000_0184,0,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 1,32'h8000_0184,0,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(0,0,0,0,1,3,0,32'h0040_0010,0, 1,32'h8000_0184,0,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(0,1,32'h8888_8888,0,0,0,0,0,0, 1,EXC_PC,0,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(0,0,0,0,1,1,32'h0000_1000,0,0, 1,EXC_PC,0,32'h1111_0005,EXC_PC));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 1,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,RST_PC,0,0,RST_PC));
        vecs.push_back(mk(0,0,0,0,1,1,32'h0000_2000,0,0, 1,32'h0000_2000,0,0,RST_PC));
        vecs.push_back(mk(0,1,32'h9999_9999,0,1,1,32'hFFFF_FFFC,0,0, 1,32'hFFFF_FFFC,0,0,RST_PC));
        vecs.push_back(mk(0,1,32'h1111_0006,0,0,0,0,0,0, 0,32'hFFFF_FFFC,1,32'h1111_0006,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,0, 1,32'h0000_0000,0,32'h1111_0006,32'hFFFF_FFFC));
        vecs.push_back(mk(0,1,32'h1111_0007,0,0,0,0,0,0, 0,32'h0000_0000,1,32'h1111_0007,32'h0000_0000));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 1,EXC_PC,0,32'h1111_0007,32'h0000_0000));

        clearInputs();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_ipc);
        end

        // Wait-state latency: inst_valid must appear right after the ack edge
        // for 0..3 wait states, with the acked word.
        @(negedge clk); clearInputs(); PcReSet = 1'b1;
        @(negedge clk); PcReSet = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int seen;
            seen = -1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                imem_ack   = (c == k);
                imem_rdata = 32'hC0DE_0000 + 32'(k);
                inst_ready = 1'b0;
                @(posedge clk); #1;
                if (inst_valid) begin
                    seen = c;
                    break;
                end
            end
            checkField($sformatf("latency_ws%0d", k), 32'(seen), 32'(k));
            checkField($sformatf("latency_data_ws%0d", k), inst, 32'hC0DE_0000 + 32'(k));
            @(negedge clk); imem_ack = 1'b0; inst_ready = 1'b1;
            @(posedge clk); #1;
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            PcReSet     = (i == 0) || ($urandom_range(0, 299) == 0);
            imem_ack    = m_req && ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            inst_ready  = 1'($urandom_range(0, 1));
            redir_valid = ($urandom_range(0, 7) == 0);
            exc_valid   = ($urandom_range(0, 19) == 0);
            NPCOp       = 2'($urandom_range(0, 3));
            Adress      = $urandom;
            redir_pc    = $urandom & 32'hFFFF_FFFC;
            @(posedge clk);
            modelStep();
            #1;
            checkOutput($sformatf("rand%0d", i), m_req, m_pc, m_valid, m_inst, m_ipc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
